// File: rtl/xg_pkg.sv
// Shared types and helpers for the 10G tester TX path: FSM state, arbitration
// mode encodings and the round-robin next-grant search.
package xg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

    localparam int MAX_CH = 16;

    // First eligible channel after 'last', wrapping modulo n; returns 'last' if none.
    function automatic logic [3:0] rr_next(input logic [MAX_CH-1:0] elig,
                                           input logic [3:0]        last,
                                           input int                n);
        logic [3:0] res;
        logic       found;
        int         idx;
        res   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(last) + k) % n;
            if (!found && k <= n && elig[idx[3:0]]) begin
                found = 1'b1;
                res   = idx[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice: full throughput, and s_tready depends
// only on local flops so there is no combinational path from m_tready.
module axis_skid_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W/8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic [DATA_W-1:0] out_data_q, out_data_d, skd_data_q, skd_data_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d, skd_keep_q, skd_keep_d;
    logic              out_last_q, out_last_d, skd_last_q, skd_last_d;
    logic              out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
    logic              pop, push;

    assign pop  = out_vld_q & m_tready;
    assign push = s_tvalid & ~skd_vld_q;

    always_comb begin
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;
        skd_data_d = skd_data_q;
        skd_keep_d = skd_keep_q;
        skd_last_d = skd_last_q;
        skd_vld_d  = skd_vld_q;
        if (skd_vld_q) begin
            // Input is stalled while the spare entry is full; drain it first.
            if (pop) begin
                out_data_d = skd_data_q;
                out_keep_d = skd_keep_q;
                out_last_d = skd_last_q;
                skd_vld_d  = 1'b0;
            end
        end else if (push) begin
            if (!out_vld_q || pop) begin
                out_data_d = s_tdata;
                out_keep_d = s_tkeep;
                out_last_d = s_tlast;
                out_vld_d  = 1'b1;
            end else begin
                skd_data_d = s_tdata;
                skd_keep_d = s_tkeep;
                skd_last_d = s_tlast;
                skd_vld_d  = 1'b1;
            end
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
            skd_data_q <= '0;
            skd_keep_q <= '0;
            skd_last_q <= 1'b0;
            skd_vld_q  <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
            skd_data_q <= skd_data_d;
            skd_keep_q <= skd_keep_d;
            skd_last_q <= skd_last_d;
            skd_vld_q  <= skd_vld_d;
        end
    end

    assign s_tready = ~skd_vld_q;
    assign m_tdata  = out_data_q;
    assign m_tkeep  = out_keep_q;
    assign m_tlast  = out_last_q;
    assign m_tvalid = out_vld_q;

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-atomic AXI-Stream arbiter (round-robin or strict priority) feeding the
// XGMAC TX queue. Define AXIS_FRAME_ARB_STATS_EN to build per-channel frame counters.
module axis_frame_arb
    import xg_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 64,
    parameter int KEEP_W   = DATA_W/8,
    parameter int CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS*DATA_W-1:0]    s_tdata,
    input  logic [CHANNELS*KEEP_W-1:0]    s_tkeep,
    input  logic [CHANNELS-1:0]           s_tvalid,
    input  logic [CHANNELS-1:0]           s_tlast,
    output logic [CHANNELS-1:0]           s_tready,
    output logic [DATA_W-1:0]             m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    input  logic                          mode,
    input  logic [CHANNELS-1:0]           chan_enable,
    output logic                          busy,
    output logic [$clog2(CHANNELS)-1:0]   cur_chan,
    input  logic                          stats_clear,
    output logic [CHANNELS*CNT_W-1:0]     frame_cnt
);

    localparam int CH_W = $clog2(CHANNELS);

    arb_state_e          state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CHANNELS-1:0] elig;
    logic [MAX_CH-1:0]   elig_ext;
    logic [CH_W-1:0]     rr_pick, prio_pick;
    logic                in_valid, in_acc, skid_rdy;
    logic [DATA_W-1:0]   in_tdata;
    logic [KEEP_W-1:0]   in_tkeep;
    logic                in_tlast;
    logic [CHANNELS-1:0] ch_done;

    assign elig = s_tvalid & chan_enable;

    always_comb begin
        elig_ext                 = '0;
        elig_ext[CHANNELS-1:0]   = elig;
    end

    // grant_q doubles as last_grant, so the search resumes one past it.
    assign rr_pick = CH_W'(rr_next(elig_ext, 4'(grant_q), CHANNELS));

    always_comb begin
        prio_pick = '0;
        for (int i = CHANNELS-1; i >= 0; i--) begin
            if (elig[i]) prio_pick = CH_W'(i);
        end
    end

    assign in_valid = (state_q == XFER) & s_tvalid[grant_q];
    assign in_tdata = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign in_tkeep = s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign in_tlast = s_tlast[grant_q];
    assign in_acc   = in_valid & skid_rdy;

    always_comb begin
        s_tready = '0;
        if (state_q == XFER) s_tready[grant_q] = skid_rdy;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    grant_d = (mode == MODE_PRIO) ? prio_pick : rr_pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (in_acc && in_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= CH_W'(CHANNELS-1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    axis_skid_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (in_tdata),
        .s_tkeep  (in_tkeep),
        .s_tlast  (in_tlast),
        .s_tvalid (in_valid),
        .s_tready (skid_rdy),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    assign busy     = (state_q == XFER);
    assign cur_chan = grant_q;
    assign ch_done  = s_tvalid & s_tready & s_tlast;

`ifdef AXIS_FRAME_ARB_STATS_EN
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (stats_clear) begin
                cnt_d[i] = '0;
            end else if (ch_done[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign frame_cnt = cnt_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clear | (|ch_done);
    assign frame_cnt    = '0;
`endif

endmodule

// File: tb/tb_axis_frame_arb.sv
// Scoreboard bench for axis_frame_arb: beats are queued as the DUT accepts them
// at the input and popped/compared as they leave the output stage.
module tb_axis_frame_arb;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 8;
`ifdef AXIS_FRAME_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH*DW-1:0]  s_tdata = '0;
    logic [CH*KW-1:0]  s_tkeep = '0;
    logic [CH-1:0]     s_tvalid = '0;
    logic [CH-1:0]     s_tlast = '0;
    logic [CH-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid, m_tlast;
    logic              m_tready = 1'b1;
    logic              mode = 1'b0;
    logic [CH-1:0]     chan_enable = '1;
    logic              busy;
    logic [1:0]        cur_chan;
    logic              stats_clear = 1'b0;
    logic [CH*CW-1:0]  frame_cnt;

    beat_t             src_q [CH][$];
    beat_t             exp_q [$];
    int                out_ch [$];
    int                eo [$];
    logic [CH-1:0]     take = '0;
    logic [CH-1:0]     gate = '1;
    bit                bp_en = 1'b0;
    bit                stall_prev = 1'b0;
    logic [DW+KW+1:0]  hold;
    beat_t             e_b;
    int                n_chk = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    axis_frame_arb #(.CHANNELS(CH), .DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .mode(mode), .chan_enable(chan_enable), .busy(busy), .cur_chan(cur_chan),
        .stats_clear(stats_clear), .frame_cnt(frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return STATS ? v : 0;
    endfunction

    function automatic beat_t mk(input int c, input int f, input int b, input bit last,
                                 input logic [KW-1:0] keep);
        beat_t r;
        r.d = {8'(c), 16'(f), 8'(b), 32'($urandom)};
        r.k = keep;
        r.l = last;
        return r;
    endfunction

    task automatic push_frame(input int c, input int f, input int len);
        for (int b = 0; b < len; b++) src_q[c].push_back(mk(c, f, b, b == len-1, 8'hFF));
    endtask

    // Monitor on the falling edge, source/ready driver just after the rising edge.
    always begin
        @(negedge clk);
        if (reset_n) begin
            if (stall_prev) check_eq("stall_stable", {m_tvalid, m_tdata, m_tkeep, m_tlast}, hold);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
                else begin
                    e_b = exp_q.pop_front();
                    check_eq("beat", {m_tdata, m_tkeep, m_tlast}, e_b);
                end
                if (m_tlast) out_ch.push_back(int'(m_tdata[63:56]));
            end
            for (int c = 0; c < CH; c++) begin
                take[c] = s_tvalid[c] && s_tready[c];
                if (take[c] && src_q[c].size() > 0) exp_q.push_back(src_q[c][0]);
            end
            stall_prev = m_tvalid && !m_tready;
            hold       = {m_tvalid, m_tdata, m_tkeep, m_tlast};
        end else begin
            take       = '0;
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (take[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (gate[c] && src_q[c].size() > 0) begin
                s_tvalid[c]         = 1'b1;
                s_tdata[c*DW +: DW] = src_q[c][0].d;
                s_tkeep[c*KW +: KW] = src_q[c][0].k;
                s_tlast[c]          = src_q[c][0].l;
            end else begin
                s_tvalid[c]         = 1'b0;
                s_tdata[c*DW +: DW] = '0;
                s_tkeep[c*KW +: KW] = '0;
                s_tlast[c]          = 1'b0;
            end
        end
        m_tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic wait_drain(input logic [CH-1:0] mask, input int max_cyc, input string tag);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
            done = 1'b1;
            for (int c = 0; c < CH; c++) if (mask[c] && src_q[c].size() > 0) done = 1'b0;
            if (exp_q.size() > 0 || busy || m_tvalid) done = 1'b0;
        end
        check_eq({tag, "_drain"}, done, 1);
    endtask

    task automatic wait_hs(input int c, input int max_cyc, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_tvalid[c] && s_tready[c]) && n < max_cyc);
        check_eq(tag, s_tvalid[c] && s_tready[c], 1);
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        int errs = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= out_ch.size() || out_ch[i] != exp[i]) errs++;
        check_eq({tag, "_len"}, out_ch.size(), exp.size());
        check_eq(tag, errs, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        stats_clear = 1'b1;
        @(negedge clk);
        stats_clear = 1'b0;
    endtask

    task automatic flush();
        for (int c = 0; c < CH; c++) src_q[c].delete();
        exp_q.delete();
        out_ch.delete();
    endtask

    initial begin
        int first, last_c, n;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_m_tlast", m_tlast, 0);
        check_eq("rst_m_tdata", m_tdata, 0);
        check_eq("rst_m_tkeep", m_tkeep, 0);
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cur_chan", cur_chan, 3);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;

        // Single 3-beat frame on channel 2: latency and busy timing
        src_q[2].push_back('{d: 64'h11, k: 8'hFF, l: 1'b0});
        src_q[2].push_back('{d: 64'h22, k: 8'hFF, l: 1'b0});
        src_q[2].push_back('{d: 64'h33, k: 8'h0F, l: 1'b1});
        @(negedge clk);
        check_eq("c0_s_tready", s_tready, 0);
        check_eq("c0_m_tvalid", m_tvalid, 0);
        @(negedge clk);
        check_eq("c1_s_tready", s_tready, 4'b0100);
        check_eq("c1_busy", busy, 1);
        check_eq("c1_cur_chan", cur_chan, 2);
        check_eq("c1_m_tvalid", m_tvalid, 0);
        @(negedge clk);
        check_eq("c2_m_tvalid", m_tvalid, 1);
        @(negedge clk);
        check_eq("c3_busy", busy, 1);
        @(negedge clk);
        check_eq("c4_busy", busy, 0);
        wait_drain('1, 50, "single");
        check_eq("single_frames", out_ch.size(), 1);

        // Round-robin fairness, 400 single-beat frames from a fresh reset
        reset_n = 1'b0;
        @(negedge clk);
        flush();
        reset_n = 1'b1;
        pulse_clear();
        for (int f = 0; f < 100; f++) for (int c = 0; c < CH; c++) push_frame(c, f, 1);
        wait_drain('1, 2000, "rr");
        eo.delete();
        for (int i = 0; i < 400; i++) eo.push_back(i % 4);
        check_order("rr_order", eo);
        for (int c = 0; c < CH; c++) check_eq("rr_frame_cnt", frame_cnt[c*CW +: CW], sx(100));

        // Strict priority: channel 0 drains before channel 3
        out_ch.delete();
        mode = 1'b1;
        for (int f = 0; f < 5; f++) begin
            push_frame(0, f, 2);
            push_frame(3, f, 2);
        end
        wait_drain('1, 200, "prio");
        eo.delete();
        for (int i = 0; i < 10; i++) eo.push_back(i < 5 ? 0 : 3);
        check_order("prio_order", eo);

        // Channel 3 only wins while channel 0 is not valid
        out_ch.delete();
        gate[0] = 1'b0;
        for (int f = 0; f < 2; f++) push_frame(0, f, 4);
        for (int f = 0; f < 4; f++) push_frame(3, f, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && cur_chan == 2'd3) && n < 50);
        check_eq("prio_ch3_first", busy && cur_chan == 2'd3, 1);
        gate[0] = 1'b1;
        wait_drain('1, 300, "prio2");
        eo.delete();
        eo.push_back(3); eo.push_back(0); eo.push_back(0);
        eo.push_back(3); eo.push_back(3); eo.push_back(3);
        check_order("prio_gate_order", eo);

        // Disable channel 1 and toggle mode during beat 2 of its 8-beat frame
        out_ch.delete();
        mode = 1'b0;
        push_frame(1, 0, 8);
        for (int f = 1; f < 4; f++) push_frame(1, f, 1);
        for (int f = 0; f < 3; f++) push_frame(2, f, 1);
        wait_hs(1, 50, "mid_beat1");
        @(posedge clk);
        #1;
        chan_enable[1] = 1'b0;
        mode = ~mode;
        wait_drain(4'b0100, 300, "mid");
        repeat (5) @(negedge clk);
        eo.delete();
        eo.push_back(1); eo.push_back(2); eo.push_back(2); eo.push_back(2);
        check_order("mid_order", eo);
        check_eq("mid_ch1_left", src_q[1].size(), 3);
        check_eq("mid_idle", busy, 0);
        src_q[1].delete();
        chan_enable = '1;
        mode = 1'b0;

        // Backpressure: 1000 random frames with m_tready high 30% of cycles
        out_ch.delete();
        bp_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int c, len;
            c   = $urandom_range(0, CH-1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                src_q[c].push_back(mk(c, f, b, b == len-1, 8'($urandom_range(0, 255))));
        end
        wait_drain('1, 30000, "bp");
        check_eq("bp_frames", out_ch.size(), 1000);
        bp_en = 1'b0;

        // Throughput with m_tready held high: 16 beats in 16 consecutive cycles
        repeat (2) @(negedge clk);
        push_frame(0, 0, 16);
        first  = -1;
        last_c = -1;
        for (int i = 0; i < 100 && last_c < 0; i++) begin
            @(negedge clk);
            if (m_tvalid && m_tready) begin
                if (first < 0) first = i;
                if (m_tlast) last_c = i;
            end
        end
        check_eq("tput_span", last_c - first, 15);
        wait_drain('1, 50, "tput");

        // Reset during input beat 4 of an 8-beat frame
        out_ch.delete();
        push_frame(2, 0, 8);
        for (int k = 0; k < 3; k++) wait_hs(2, 50, "rst_mid_hs");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_m_tvalid", m_tvalid, 0);
        check_eq("rst_mid_m_tlast", m_tlast, 0);
        check_eq("rst_mid_m_tdata", m_tdata, 0);
        check_eq("rst_mid_m_tkeep", m_tkeep, 0);
        check_eq("rst_mid_s_tready", s_tready, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_cur_chan", cur_chan, 3);
        check_eq("rst_mid_frame_cnt", frame_cnt, 0);
        flush();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_frame(3, 0, 1);
        push_frame(1, 0, 1);
        push_frame(0, 0, 1);
        wait_drain('1, 50, "post_rst");
        eo.delete();
        eo.push_back(0); eo.push_back(1); eo.push_back(3);
        check_order("post_rst_order", eo);

        // Counter saturation and clear-versus-increment
        pulse_clear();
        for (int f = 0; f < 255; f++) push_frame(0, f, 1);
        wait_drain('1, 2000, "sat");
        check_eq("sat_full", frame_cnt[0 +: CW], sx(255));
        push_frame(0, 255, 1);
        wait_drain('1, 50, "sat2");
        check_eq("sat_hold", frame_cnt[0 +: CW], sx(255));
        push_frame(1, 0, 1);
        wait_drain('1, 50, "clr_pre");
        check_eq("clr_pre_cnt", frame_cnt[CW +: CW], sx(1));
        push_frame(1, 1, 1);
        wait_hs(1, 50, "clr_hs");
        stats_clear = 1'b1;
        @(negedge clk);
        stats_clear = 1'b0;
        wait_drain('1, 50, "clr");
        check_eq("clr_wins_ch1", frame_cnt[CW +: CW], 0);
        check_eq("clr_wins_ch0", frame_cnt[0 +: CW], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_arb.md
# axis_frame_arb

Parametrised multi-channel AXI-Stream frame arbiter for the 10G tester TX path. It merges CHANNELS independent AXI-Stream sources into the single AXI-Stream stream that feeds the XGMAC transmit queue. Arbitration is frame-atomic: a granted channel keeps the output until its tlast beat is accepted. The block runs entirely in the system clock domain, upstream of the TX clock-domain crossing.

## Interface
- CHANNELS, 4: number of input streams (2..16).
- DATA_W, 64: data width per beat, a multiple of 8.
- KEEP_W, DATA_W/8: tkeep width.
- CNT_W, 32: width of each per-channel frame counter.
- clk  in  1  system clock (160 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- s_tdata  in  CHANNELS*DATA_W  input data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_tkeep  in  CHANNELS*KEEP_W  input byte enables.
- s_tvalid  in  CHANNELS  per-channel valid.
- s_tlast  in  CHANNELS  per-channel end of frame.
- s_tready  out  CHANNELS  per-channel ready.
- m_tdata / m_tkeep  out  DATA_W / KEEP_W  merged output data and byte enables.
- m_tvalid / m_tlast  out  1  output valid and end of frame.
- m_tready  in  1  downstream ready.
- mode  in  1  arbitration mode: 0 is round-robin, 1 is strict priority (lowest index wins).
- chan_enable  in  CHANNELS  a channel is eligible only when its bit is 1.
- busy  out  1  a frame is currently granted.
- cur_chan  out  $clog2(CHANNELS)  index of the granted (or last granted) channel.
- stats_clear  in  1  synchronous clear of all frame counters.
- frame_cnt  out  CHANNELS*CNT_W  per-channel count of completed frames.

## Operation
- FSM states:
  - IDLE: if any channel has s_tvalid & chan_enable, pick a winner and register the grant, then go to XFER.
  - XFER: route the winner to the output stage. When a beat with s_tlast is accepted, go back to IDLE.
- Round-robin search starts at last_grant+1 modulo CHANNELS. last_grant resets to CHANNELS-1, so channel 0 wins first.
- Strict-priority mode picks the lowest eligible index.
- s_tready[i] = (state==XFER) & (grant==i) & skid-stage ready. All other s_tready bits are 0.
- mode and chan_enable are sampled only in IDLE. Clearing a channel's enable mid-frame never truncates that frame.
- Beats with zero tkeep pass through unmodified. The block does not check tkeep contiguity.
- Output passes through a two-entry skid register, which gives full throughput with no combinational m_tready→s_tready path.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, s_tready=0, busy=0, cur_chan=CHANNELS-1, frame_cnt=0, state=IDLE.
- Reset asserted mid-frame:
  - Everything is cleared immediately.
  - Any partial frame already emitted stays unterminated; the downstream tx queue is reset together with this block.

## Timing
- Arbitration latency: s_tvalid rises in IDLE at cycle 0, the grant is registered at cycle 1, s_tready is high at cycle 1, and the first m_tvalid appears at cycle 2.
- Back-to-back frames carry exactly one idle cycle on the input side, between the tlast acceptance and the next grant.
- Sustained throughput within a frame is one beat per clock while m_tready=1.
- Once m_tvalid is high, m_tdata, m_tkeep and m_tlast stay stable until m_tready is sampled high.
- busy rises the cycle after the grant decision and falls the cycle after tlast is accepted at the input.

## Configuration
- AXIS_FRAME_ARB_STATS_EN defined:
  - frame_cnt[i] increments on each accepted input beat with s_tlast from channel i.
  - Counters saturate at all ones.
  - stats_clear forces the counter to 0 and wins over a same-cycle increment.
- Not defined: frame_cnt is tied to 0, stats_clear is ignored and no counter flops are synthesised.

## Structure
- Shared package xg_pkg holds:
  - the state enum (IDLE, XFER);
  - the arbitration mode constants MODE_RR=1'b0 and MODE_PRIO=1'b1;
  - the function that computes the round-robin next grant.
- One sub-module, axis_skid_reg (parameters DATA_W and KEEP_W): a two-entry AXI-Stream register slice used for the output stage.

## Test plan
- Single channel: channel 2 sends a 3-beat frame with data 0x11, 0x22, 0x33 and last tkeep 0x0F, m_tready=1.
  - Required: m_tvalid from cycle 2, the three beats in order, m_tlast only on beat 3, m_tkeep=0x0F on beat 3.
- Round-robin fairness: all 4 channels continuously send 1-beat frames, mode=0.
  - Required: output channel order is 0,1,2,3,0,…
  - Required: after 400 frames each frame_cnt equals 100 (STATS_EN defined).
- Strict priority: channels 0 and 3 both valid, mode=1.
  - Required: every frame from channel 0 is granted before any from channel 3.
  - Required: channel 3 wins only while channel 0's tvalid is low.
- Mid-frame control changes: clear chan_enable[1] and toggle mode during beat 2 of an 8-beat frame on channel 1.
  - Required: all 8 beats are emitted, then channel 1 is never granted again.
- Backpressure: random m_tready at 30% high across 1000 frames.
  - Required: no beat lost or duplicated, output stable while stalled, one-beat-per-clock throughput once m_tready=1.
- Reset and counter boundaries:
  - reset_n low during beat 4: all outputs read their reset values the same cycle; channel 0 wins first after reset release.
  - Counter preloaded to 0xFFFFFFFF stays saturated on the next frame.
  - stats_clear in the same cycle as a counted tlast gives 0.
